bcd_display_scan: RTL and testbench

//  Consumes the packed BCD digits produced by the cascaded decade counters and drives a

---
 rtl/clock_display_pkg.sv | 48 ++++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/bcd_display_scan.sv | 114 +++++++++++
 tb/tb_bcd_display_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Glyphs are active-low, packed {g,f,e,d,c,b,a}.
package clock_display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] BIT_A = 7'(1) << SEG_A;
  localparam logic [6:0] BIT_B = 7'(1) << SEG_B;
  localparam logic [6:0] BIT_C = 7'(1) << SEG_C;
  localparam logic [6:0] BIT_D = 7'(1) << SEG_D;
  localparam logic [6:0] BIT_E = 7'(1) << SEG_E;
  localparam logic [6:0] BIT_F = 7'(1) << SEG_F;
  localparam logic [6:0] BIT_G = 7'(1) << SEG_G;

  // Each glyph lists its lit segments, then inverts for the common-anode pins.
  localparam logic [6:0] SEG_0    = ~(BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F);
  localparam logic [6:0] SEG_1    = ~(BIT_B | BIT_C);
  localparam logic [6:0] SEG_2    = ~(BIT_A | BIT_B | BIT_D | BIT_E | BIT_G);
  localparam logic [6:0] SEG_3    = ~(BIT_A | BIT_B | BIT_C | BIT_D | BIT_G);
  localparam logic [6:0] SEG_4    = ~(BIT_B | BIT_C | BIT_F | BIT_G);
  localparam logic [6:0] SEG_5    = ~(BIT_A | BIT_C | BIT_D | BIT_F | BIT_G);
  localparam logic [6:0] SEG_6    = ~(BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G);
  localparam logic [6:0] SEG_7    = ~(BIT_A | BIT_B | BIT_C);
  localparam logic [6:0] SEG_8    = ~(BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G);
  localparam logic [6:0] SEG_9    = ~(BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G);
  localparam logic [6:0] SEG_DASH = ~BIT_G;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Never returns less than 1 so it is always usable as a vector width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 render a dash.
module bcd_to_seg7
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode display scanner with frame-synchronous digit capture.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_scan
  import clock_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       bcd,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [clog2(NUM_DIGITS)-1:0]  idx
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]        count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    scan_tick;
  logic [3:0]              cur_digit;
  logic [6:0]              cur_glyph;
  logic                    blank;

  always_comb begin
    scan_tick    = en && (count_q == CNT_LAST);
    count_d      = count_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    if (en) begin
      count_d = scan_tick ? '0 : count_q + 1'b1;
    end
    if (scan_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      // Capture only at the frame boundary so a frame never mixes old and new digits.
      if (idx_q == IDX_LAST) begin
        shadow_bcd_d = bcd;
        shadow_dp_d  = dp_in;
      end
    end
  end

  assign cur_digit = shadow_bcd_q[4*idx_q +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // zero_above[k] is set when shadow digits k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS:0] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_above[gi] = zero_above[gi+1] && (shadow_bcd_q[4*gi +: 4] == 4'd0);
    end
  endgenerate
  assign blank = (idx_q != '0) && zero_above[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (en) begin
      seg_d        = blank ? SEG_OFF : cur_glyph;
      dp_d         = ~shadow_dp_q[idx_q];
      an_d[idx_q]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q      <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      count_q      <= count_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign idx = idx_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench: enabled-cycle arithmetic reference model plus directed and random stimulus.
module tb_bcd_display_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk   = 1'b0;
  logic        clrn  = 1'b0;
  logic        en    = 1'b0;
  logic [15:0] bcd   = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  idx;

  always #5 clk = ~clk;

  bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .en    (en),
    .bcd   (bcd),
    .dp_in (dp_in),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .idx   (idx)
  );

  int vectors     = 0;
  int miscompares = 0;
  string phase    = "init";

  // Model state: n = enabled clock edges since reset; frame_* = digits shown this frame.
  int          n;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_dp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    n         = 0;
    frame_bcd = 16'h0;
    frame_dp  = 4'h0;
    e_seg     = 7'h7F;
    e_dp      = 1'b1;
    e_an      = 4'hF;
  endtask

  task automatic model_edge();
    int          slot;
    logic [15:0] upper;
    if (!clrn) begin
      model_reset();
      return;
    end
    if (!en) begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = 4'hF;
      return;
    end
    slot  = (n / RD) % ND;
    upper = frame_bcd >> (4 * slot);
    e_an  = 4'hF & ~(4'b0001 << slot);
    e_seg = glyph[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && upper == 16'h0) e_seg = 7'h7F;
`endif
    e_dp = ~frame_dp[slot];
    // The last enabled edge of each frame loads the digits used by the next frame.
    if (((n + 1) % (RD * ND)) == 0) begin
      frame_bcd = bcd;
      frame_dp  = dp_in;
    end
    n++;
  endtask

  task automatic check_outputs();
    chk({phase, ":seg"}, 32'(seg), 32'(e_seg));
    chk({phase, ":dp"},  32'(dp),  32'(e_dp));
    chk({phase, ":an"},  32'(an),  32'(e_an));
    chk({phase, ":idx"}, 32'(idx), 32'((n / RD) % ND));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic run_until(input int target);
    for (int k = 0; k < 64 && (n % (RD * ND)) != target; k++) tick();
    chk({phase, ":sync"}, 32'(n % (RD * ND)), 32'(target));
  endtask

  // Asserted between edges so the asynchronous path is what darkens the outputs.
  task automatic async_reset();
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick();
    tick();
    clrn = 1'b1;
  endtask

  initial begin
    model_reset();
    en  = 1'b1;
    bcd = 16'h1234;

    phase = "reset";
    run(2);
    clrn = 1'b1;

    phase = "t1_scan";
    run(40);

    phase = "t2_tear";
    run_until(6);
    bcd = 16'h5678;
    run(32);

    phase = "t3_dash";
    bcd = 16'h00AF;
    run(32);

    phase = "t4_freeze";
    bcd = 16'h1234;
    run_until(9);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(20);

    phase = "t5_reset";
    run_until(13);
    async_reset();
    run(20);

    phase = "t6_dp";
    dp_in = 4'b0100;
    bcd   = 16'h1200;
    run(40);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bcd = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
